// File: rtl/dm_pkg.sv
// Shared debug-module package: DMI operation status codes.
package DM;

    typedef enum logic [1:0] {
        DTM_SUCCESS = 2'h0,
        DTM_ERR     = 2'h2,
        DTM_BUSY    = 2'h3
    } dtm_op_status_e;

endpackage

// File: rtl/dm_fifo_ctrl.sv
// Pointer/count/flag bookkeeping for the debug-module response queue.
module dm_fifo_ctrl #(
    parameter int unsigned Depth = 2,
    parameter int unsigned PtrW  = $clog2(Depth),
    parameter int unsigned CntW  = $clog2(Depth) + 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            dmactive_i,
    input  logic            push_i,
    input  logic            ready_i,
    output logic            wr_en_o,
    output logic [PtrW-1:0] wr_ptr_o,
    output logic [PtrW-1:0] rd_ptr_o,
    output logic            full_o,
    output logic            empty_o,
    output logic [CntW-1:0] usage_o,
    output logic            overflow_o
);

    localparam logic [PtrW-1:0] PtrOne  = PtrW'(1);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);
    localparam logic [CntW-1:0] CntFull = CntW'(Depth);

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            overflow_q, overflow_d;
    logic            pop, push_ok;

    always_comb begin
        // A pop only counts when the head is valid, so push+pop on empty is just a push.
        pop        = (count_q != '0) && ready_i;
        push_ok    = push_i && ((count_q != CntFull) || pop);
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (!dmactive_i) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (pop)     rd_ptr_d = rd_ptr_q + PtrOne;
            if (push_ok) wr_ptr_d = wr_ptr_q + PtrOne;
            case ({push_ok, pop})
                2'b10:   count_d = count_q + CntOne;
                2'b01:   count_d = count_q - CntOne;
                default: count_d = count_q;
            endcase
            if (push_i && !push_ok) overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign wr_en_o    = push_ok && dmactive_i;
    assign wr_ptr_o   = wr_ptr_q;
    assign rd_ptr_o   = rd_ptr_q;
    assign full_o     = (count_q == CntFull);
    assign empty_o    = (count_q == '0);
    assign usage_o    = count_q;
    assign overflow_o = overflow_q;

endmodule

// File: rtl/dm_resp_queue.sv
// In-order response buffer from the DM control unit to the DMI front end.
module dm_resp_queue #(
    parameter int unsigned Depth     = 2,
    parameter int unsigned DataWidth = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     dmactive_i,
    input  logic                     push_i,
    input  logic [DataWidth-1:0]     push_data_i,
    input  logic [1:0]               push_resp_i,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(Depth):0]   usage_o,
    output logic                     overflow_o,
    output logic                     resp_valid_o,
    input  logic                     resp_ready_i,
    output logic [DataWidth-1:0]     resp_data_o,
    output logic [1:0]               resp_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned EntW = DataWidth + 2;

    logic [Depth-1:0][EntW-1:0] mem_q, mem_d;
    logic                       wr_en;
    logic [PtrW-1:0]            wr_ptr, rd_ptr;

    dm_fifo_ctrl #(
        .Depth (Depth)
    ) u_ctrl (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .dmactive_i (dmactive_i),
        .push_i     (push_i),
        .ready_i    (resp_ready_i),
        .wr_en_o    (wr_en),
        .wr_ptr_o   (wr_ptr),
        .rd_ptr_o   (rd_ptr),
        .full_o     (full_o),
        .empty_o    (empty_o),
        .usage_o    (usage_o),
        .overflow_o (overflow_o)
    );

    always_comb begin
        mem_d = mem_q;
        if (wr_en) mem_d[wr_ptr] = {push_resp_i, push_data_i};
    end

    // Storage is deliberately left out of reset and flush.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    assign resp_valid_o = !empty_o;
    assign {resp_o, resp_data_o} = mem_q[rd_ptr];

endmodule

// File: tb/tb_dm_resp_queue.sv
// Directed bench for dm_resp_queue at Depth=2.
module tb_dm_resp_queue;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        dmactive_i;
    logic        push_i;
    logic [31:0] push_data_i;
    logic [1:0]  push_resp_i;
    logic        full_o, empty_o, overflow_o, resp_valid_o;
    logic [1:0]  usage_o;
    logic        resp_ready_i;
    logic [31:0] resp_data_o;
    logic [1:0]  resp_o;

    int passed = 0;
    int total  = 0;

    dm_resp_queue #(.Depth(2), .DataWidth(32)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .dmactive_i   (dmactive_i),
        .push_i       (push_i),
        .push_data_i  (push_data_i),
        .push_resp_i  (push_resp_i),
        .full_o       (full_o),
        .empty_o      (empty_o),
        .usage_o      (usage_o),
        .overflow_o   (overflow_o),
        .resp_valid_o (resp_valid_o),
        .resp_ready_i (resp_ready_i),
        .resp_data_o  (resp_data_o),
        .resp_o       (resp_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_push(input logic p, input logic [31:0] d, input logic [1:0] r);
        push_i      = p;
        push_data_i = d;
        push_resp_i = r;
    endtask

    initial begin
        rst_ni = 1'b0; dmactive_i = 1'b1; resp_ready_i = 1'b0;
        set_push(1'b0, 32'h0, 2'd0);
        #12;
        chk("rst_empty", empty_o, 1);
        chk("rst_valid", resp_valid_o, 0);
        chk("rst_full", full_o, 0);
        chk("rst_usage", usage_o, 0);
        chk("rst_ovf", overflow_o, 0);
        rst_ni = 1'b1;
        step();
        chk("idle_empty", empty_o, 1);

        // single push, 1-cycle latency
        set_push(1'b1, 32'hDEADBEEF, DM::DTM_SUCCESS);
        step();
        set_push(1'b0, 32'h0, 2'd0);
        chk("p1_valid", resp_valid_o, 1);
        chk("p1_data", resp_data_o, 32'hDEADBEEF);
        chk("p1_resp", resp_o, 0);
        chk("p1_usage", usage_o, 1);
        resp_ready_i = 1'b1; step(); resp_ready_i = 1'b0;
        chk("p1_drained", empty_o, 1);

        // fill, overflow, drain
        set_push(1'b1, 32'hA, DM::DTM_ERR); step();
        set_push(1'b1, 32'hB, DM::DTM_BUSY); step();
        chk("fill_full", full_o, 1);
        chk("fill_usage", usage_o, 2);
        set_push(1'b1, 32'hC, DM::DTM_SUCCESS); step();
        set_push(1'b0, 32'h0, 2'd0);
        chk("ovf_set", overflow_o, 1);
        chk("ovf_usage", usage_o, 2);
        chk("drain_a", resp_data_o, 32'hA);
        chk("drain_a_resp", resp_o, 2);
        resp_ready_i = 1'b1; step();
        chk("drain_b", resp_data_o, 32'hB);
        chk("drain_b_resp", resp_o, 3);
        step(); resp_ready_i = 1'b0;
        chk("drain_empty", empty_o, 1);
        chk("ovf_sticky", overflow_o, 1);

        // push+pop while full
        set_push(1'b1, 32'hA, DM::DTM_SUCCESS); step();
        set_push(1'b1, 32'hB, DM::DTM_SUCCESS); step();
        set_push(1'b1, 32'hD, DM::DTM_ERR); resp_ready_i = 1'b1; step();
        set_push(1'b0, 32'h0, 2'd0);
        chk("fpp_usage", usage_o, 2);
        chk("fpp_head_b", resp_data_o, 32'hB);
        step();
        chk("fpp_head_d", resp_data_o, 32'hD);
        chk("fpp_d_resp", resp_o, 2);
        step(); resp_ready_i = 1'b0;
        chk("fpp_empty", empty_o, 1);

        // push+ready on empty: no fall-through
        set_push(1'b1, 32'hE, DM::DTM_SUCCESS); resp_ready_i = 1'b1; step();
        set_push(1'b0, 32'h0, 2'd0);
        chk("epp_usage", usage_o, 1);
        chk("epp_valid", resp_valid_o, 1);
        chk("epp_data", resp_data_o, 32'hE);
        step(); resp_ready_i = 1'b0;
        chk("epp_popped", empty_o, 1);

        // flush with pending push/pop ignored
        set_push(1'b1, 32'h11, DM::DTM_SUCCESS); step();
        set_push(1'b1, 32'h22, DM::DTM_SUCCESS); step();
        chk("fl_pre_usage", usage_o, 2);
        chk("fl_pre_ovf", overflow_o, 1);
        set_push(1'b1, 32'h33, DM::DTM_SUCCESS); resp_ready_i = 1'b1; dmactive_i = 1'b0; step();
        set_push(1'b0, 32'h0, 2'd0); resp_ready_i = 1'b0; dmactive_i = 1'b1;
        chk("fl_empty", empty_o, 1);
        chk("fl_usage", usage_o, 0);
        chk("fl_ovf", overflow_o, 0);
        chk("fl_full", full_o, 0);

        // wrap-around
        for (int i = 1; i <= 5; i++) begin
            set_push(1'b1, 32'(i), DM::DTM_SUCCESS); step();
            set_push(1'b0, 32'h0, 2'd0);
            chk($sformatf("wrap_%0d", i), resp_data_o, 64'(i));
            chk($sformatf("wrap_use_%0d", i), usage_o, 1);
            resp_ready_i = 1'b1; step(); resp_ready_i = 1'b0;
        end
        chk("wrap_empty", empty_o, 1);

        // asynchronous reset mid-operation
        set_push(1'b1, 32'h55, DM::DTM_SUCCESS); step();
        set_push(1'b1, 32'h66, DM::DTM_SUCCESS); step();
        set_push(1'b1, 32'h77, DM::DTM_SUCCESS); step();
        set_push(1'b0, 32'h0, 2'd0);
        chk("ar_pre_ovf", overflow_o, 1);
        #2 rst_ni = 1'b0;
        #1;
        chk("ar_empty", empty_o, 1);
        chk("ar_usage", usage_o, 0);
        chk("ar_ovf", overflow_o, 0);
        step();
        rst_ni = 1'b1;
        set_push(1'b1, 32'h99, DM::DTM_BUSY); step();
        set_push(1'b0, 32'h0, 2'd0);
        chk("ar_post_usage", usage_o, 1);
        chk("ar_post_data", resp_data_o, 32'h99);
        chk("ar_post_resp", resp_o, 3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
